reverse_dimensions: RTL and testbench

Registered transposer for a packed 2-D array. It takes a D1_WIDTH x D2_WIDTH array of ELEM_W-bit elements and emits the D2_WIDTH x D1_WIDTH array with dimensions swapped: out[j][i] = in[i][j]. It sits between bit-sliced datapaths, for example to convert lane-major words into bit-major words, behind a valid/ready handshake.

---
 rtl/reverse_dimensions_pkg.sv | 34 +++
 rtl/rd_skid_buffer.sv | 66 ++++++
 rtl/reverse_dimensions.sv | 79 +++++++
 tb/tb_reverse_dimensions.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/reverse_dimensions_pkg.sv
`default_nettype none
// ============================================================================
// Module      : reverse_dimensions_pkg
// Description : Default sizes and a reference transpose for reverse_dimensions.
// Revision    : 1.0 - initial release
// ============================================================================
package reverse_dimensions_pkg;

    localparam int RD_D1_DEF     = 2;
    localparam int RD_D2_DEF     = 8;
    localparam int RD_ELEM_W_DEF = 1;
    localparam int RD_MAX_BITS   = 1024;

    // Flat-vector transpose: element (i,j) of a d1 x d2 array moves to (j,i).
    function automatic logic [RD_MAX_BITS-1:0] rd_transpose(
        input logic [RD_MAX_BITS-1:0] src,
        input int                     d1,
        input int                     d2,
        input int                     ew
    );
        logic [RD_MAX_BITS-1:0] dst;
        dst = '0;
        for (int i = 0; i < d1; i++) begin
            for (int j = 0; j < d2; j++) begin
                for (int b = 0; b < ew; b++) begin
                    dst[(j*d1+i)*ew+b] = src[(i*d2+j)*ew+b];
                end
            end
        end
        return dst;
    endfunction

endpackage
`default_nettype wire

// File: rtl/rd_skid_buffer.sv
`default_nettype none
// ============================================================================
// Module      : rd_skid_buffer
// Description : Generic 2-entry valid/ready buffer with a registered in_ready.
// Revision    : 1.0 - initial release
// ============================================================================
module rd_skid_buffer #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             nrst,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready
);

    logic [1:0][WIDTH-1:0] r_mem;
    logic                  r_wr_ptr;
    logic                  r_rd_ptr;
    logic [1:0]            r_count;
    logic                  r_in_ready;
    logic [1:0]            w_count_nxt;
    logic                  w_push;
    logic                  w_pop;

    assign in_ready  = r_in_ready;
    assign out_valid = (r_count != 2'd0);
    assign out_data  = r_mem[r_rd_ptr];
    assign w_push    = in_valid & r_in_ready;
    assign w_pop     = out_valid & out_ready;

    always_comb begin
        w_count_nxt = r_count;
        case ({w_push, w_pop})
            2'b10:   w_count_nxt = r_count + 2'd1;
            2'b01:   w_count_nxt = r_count - 2'd1;
            default: w_count_nxt = r_count;
        endcase
    end

    // in_ready looks ahead at the next occupancy so it never depends on out_ready.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_mem      <= '0;
            r_wr_ptr   <= 1'b0;
            r_rd_ptr   <= 1'b0;
            r_count    <= 2'd0;
            r_in_ready <= 1'b1;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= in_data;
                r_wr_ptr        <= ~r_wr_ptr;
            end
            if (w_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            r_count    <= w_count_nxt;
            r_in_ready <= (w_count_nxt != 2'd2);
        end
    end

endmodule
`default_nettype wire

// File: rtl/reverse_dimensions.sv
`default_nettype none
// ============================================================================
// Module      : reverse_dimensions
// Description : Registered transposer of a packed D1 x D2 array behind valid/ready.
//               REVERSE_DIMENSIONS_SKID_EN selects a 2-entry skid buffer stage.
// Revision    : 1.0 - initial release
// ============================================================================
module reverse_dimensions
    import reverse_dimensions_pkg::*;
#(
    parameter int D1_WIDTH = RD_D1_DEF,
    parameter int D2_WIDTH = RD_D2_DEF,
    parameter int ELEM_W   = RD_ELEM_W_DEF
) (
    input  logic                                         clk,
    input  logic                                         nrst,
    input  logic [D1_WIDTH-1:0][D2_WIDTH-1:0][ELEM_W-1:0] in_data,
    input  logic                                         in_valid,
    output logic                                         in_ready,
    output logic [D2_WIDTH-1:0][D1_WIDTH-1:0][ELEM_W-1:0] out_data,
    output logic                                         out_valid,
    input  logic                                         out_ready
);

    localparam int c_WIDTH = D1_WIDTH * D2_WIDTH * ELEM_W;

    logic [D2_WIDTH-1:0][D1_WIDTH-1:0][ELEM_W-1:0] w_xpose;

    generate
        for (genvar gi = 0; gi < D1_WIDTH; gi++) begin : g_d1
            for (genvar gj = 0; gj < D2_WIDTH; gj++) begin : g_d2
                assign w_xpose[gj][gi] = in_data[gi][gj];
            end
        end
    endgenerate

`ifdef REVERSE_DIMENSIONS_SKID_EN
    logic [c_WIDTH-1:0] w_skid_data;

    rd_skid_buffer #(
        .WIDTH(c_WIDTH)
    ) u_skid (
        .clk      (clk),
        .nrst     (nrst),
        .in_data  (w_xpose),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .out_data (w_skid_data),
        .out_valid(out_valid),
        .out_ready(out_ready)
    );

    assign out_data = w_skid_data;
`else
    logic [c_WIDTH-1:0] r_data;
    logic               r_valid;

    assign in_ready  = ~r_valid | out_ready;
    assign out_valid = r_valid;
    assign out_data  = r_data;

    // Data only loads on an accepted word, so idle inputs cause no toggling.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_valid <= 1'b0;
            r_data  <= '0;
        end else begin
            if (in_ready) begin
                r_valid <= in_valid;
            end
            if (in_valid && in_ready) begin
                r_data <= w_xpose;
            end
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_reverse_dimensions.sv
`default_nettype none
// ============================================================================
// Module      : tb_reverse_dimensions
// Description : Scoreboard bench for reverse_dimensions (2x8x1, 3x2x4, 1x4x2).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_reverse_dimensions;
    import reverse_dimensions_pkg::*;

    logic clk;
    logic nrst;

    logic [1:0][7:0][0:0] in_data;
    logic                 in_valid;
    logic                 in_ready;
    logic [7:0][1:0][0:0] out_data;
    logic                 out_valid;
    logic                 out_ready;

    logic [2:0][1:0][3:0] in_data2;
    logic                 in_valid2;
    logic                 in_ready2;
    logic [1:0][2:0][3:0] out_data2;
    logic                 out_valid2;

    logic [0:0][3:0][1:0] in_data3;
    logic                 in_valid3;
    logic                 in_ready3;
    logic [3:0][0:0][1:0] out_data3;
    logic                 out_valid3;

    int n_vec;
    int n_err;
    logic [15:0] sb[$];

    reverse_dimensions u_dut (
        .clk(clk), .nrst(nrst),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready)
    );

    reverse_dimensions #(.D1_WIDTH(3), .D2_WIDTH(2), .ELEM_W(4)) u_dut2 (
        .clk(clk), .nrst(nrst),
        .in_data(in_data2), .in_valid(in_valid2), .in_ready(in_ready2),
        .out_data(out_data2), .out_valid(out_valid2), .out_ready(1'b1)
    );

    reverse_dimensions #(.D1_WIDTH(1), .D2_WIDTH(4), .ELEM_W(2)) u_dut3 (
        .clk(clk), .nrst(nrst),
        .in_data(in_data3), .in_valid(in_valid3), .in_ready(in_ready3),
        .out_data(out_data3), .out_valid(out_valid3), .out_ready(1'b1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] model(input logic [15:0] d);
        logic [RD_MAX_BITS-1:0] t;
        t = rd_transpose({{(RD_MAX_BITS-16){1'b0}}, d}, 2, 8, 1);
        return t[15:0];
    endfunction

    // One cycle of stimulus; the expected word is queued only if the DUT accepts it.
    task automatic step(input logic [15:0] d, input logic [15:0] exp, input logic v, input logic r);
        in_data   = d;
        in_valid  = v;
        out_ready = r;
        @(negedge clk);
        if (v && in_ready) sb.push_back(exp);
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (nrst && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL sb_unexpected: got %h expected no output", out_data);
            end else begin
                check("sb_data", 32'(out_data), 32'(sb.pop_front()));
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] lfsr;
        logic        hold_rdy;
        logic [RD_MAX_BITS-1:0] t;
        n_vec = 0;
        n_err = 0;
        nrst = 1'b0;
        in_data = '0; in_valid = 1'b0; out_ready = 1'b0;
        in_data2 = '0; in_valid2 = 1'b0;
        in_data3 = '0; in_valid3 = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_out_valid", 32'(out_valid), 32'd0);
        check("reset_out_data", 32'(out_data), 32'd0);
        @(negedge clk);
        nrst = 1'b1;
        @(posedge clk);
        #1;
        check("reset_in_ready", 32'(in_ready), 32'd1);

        // Latency and back-to-back throughput
        step(16'hA55A, 16'h9966, 1'b1, 1'b1);
        check("lat_valid", 32'(out_valid), 32'd1);
        check("lat_data", 32'(out_data), 32'h9966);
        check("b2b_ready0", 32'(in_ready), 32'd1);
        step(16'hFF00, 16'hAAAA, 1'b1, 1'b1);
        check("b2b_data1", 32'(out_data), 32'hAAAA);
        check("b2b_ready1", 32'(in_ready), 32'd1);
        step(16'h00FF, 16'h5555, 1'b1, 1'b1);
        check("b2b_data2", 32'(out_data), 32'h5555);
        check("b2b_valid2", 32'(out_valid), 32'd1);
        step(16'h0000, 16'h0000, 1'b0, 1'b1);
        check("drain_valid", 32'(out_valid), 32'd0);

        // Backpressure hold
`ifdef REVERSE_DIMENSIONS_SKID_EN
        hold_rdy = 1'b1;
`else
        hold_rdy = 1'b0;
`endif
        step(16'hA55A, 16'h9966, 1'b1, 1'b0);
        for (int k = 0; k < 5; k++) begin
            step(16'h0000, 16'h0000, 1'b0, 1'b0);
            check("hold_data", 32'(out_data), 32'h9966);
            check("hold_valid", 32'(out_valid), 32'd1);
            check("hold_in_ready", 32'(in_ready), 32'(hold_rdy));
        end
        step(16'h0000, 16'h0000, 1'b0, 1'b1);
        check("hold_once", 32'(out_valid), 32'd0);
        check("hold_sb_empty", 32'(sb.size()), 32'd0);
        step(16'hFF00, 16'hAAAA, 1'b1, 1'b1);
        check("hold_next", 32'(out_data), 32'hAAAA);
        step(16'h0000, 16'h0000, 1'b0, 1'b1);

        // Asynchronous reset with a held word
        step(16'hA55A, 16'h9966, 1'b1, 1'b0);
        in_valid = 1'b0;
        #2;
        nrst = 1'b0;
        #1;
        check("arst_valid", 32'(out_valid), 32'd0);
        check("arst_data", 32'(out_data), 32'd0);
        sb.delete();
        @(posedge clk);
        @(negedge clk);
        nrst = 1'b1;
        #1;
        check("arst_in_ready", 32'(in_ready), 32'd1);
        step(16'h0000, 16'h0000, 1'b0, 1'b1);
        check("arst_no_stale", 32'(out_valid), 32'd0);

        // Random traffic
        lfsr = 16'hACE1;
        for (int k = 0; k < 10000; k++) begin
            lfsr = {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
            step(lfsr, model(lfsr), ($urandom_range(0, 3) != 0), ($urandom_range(0, 3) != 0));
        end
        for (int k = 0; k < 20; k++) begin
            if (sb.size() == 0 && !out_valid) break;
            step(16'h0000, 16'h0000, 1'b0, 1'b1);
        end
        check("rand_drained", 32'(sb.size()), 32'd0);

        // 3x2 array of 4-bit elements
        in_data2 = 24'hC00000;
        in_valid2 = 1'b1;
        @(posedge clk);
        #1;
        in_valid2 = 1'b0;
        check("e4_valid", 32'(out_valid2), 32'd1);
        check("e4_elem", 32'(out_data2[1][2]), 32'hC);
        check("e4_word", 32'(out_data2), 32'hC00000);
        in_data2 = 24'h000050;
        in_valid2 = 1'b1;
        @(posedge clk);
        #1;
        in_valid2 = 1'b0;
        check("e4_word2", 32'(out_data2), 32'h005000);
        t = rd_transpose({{(RD_MAX_BITS-24){1'b0}}, 24'h000050}, 3, 2, 4);
        check("e4_model", 32'(out_data2), t[31:0]);

        // Degenerate D1=1 is a reshape
        in_data3 = 8'hB4;
        in_valid3 = 1'b1;
        @(posedge clk);
        #1;
        in_valid3 = 1'b0;
        check("d1_reshape", 32'(out_data3), 32'hB4);
        check("d1_valid", 32'(out_valid3), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
